// File: rtl/mem_stage_if.sv
// EX->MS payload, data-cache response and MS->WB / forwarding signals of the memory stage.
// The stage drives the slave side; the surrounding pipeline (or a bench) drives the master side.
interface mem_stage_if #(
  parameter int SB_WD = 64
);
  logic             es_to_ms_valid;
  logic             ms_allowin;
  logic [31:0]      es_pc;
  logic [31:0]      es_result;
  logic [4:0]       es_dest;
  logic             es_gr_we;
  logic             es_load_op;
  logic             es_store_op;
  logic [1:0]       es_mem_size;
  logic             es_mem_sign_ext;
  logic             es_excp;
  logic [SB_WD-1:0] es_sideband;
  logic             data_data_ok;
  logic [31:0]      data_rdata;
  logic             flush;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [31:0]      ms_pc;
  logic [31:0]      ms_final_result;
  logic [4:0]       ms_dest;
  logic             ms_gr_we;
  logic             ms_excp;
  logic [SB_WD-1:0] ms_sideband;
  logic             ms_flush;
  logic             ms_fwd_en;
  logic             ms_fwd_stall;
  logic [31:0]      ms_fwd_data;

  modport slave (
    input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op, es_store_op,
           es_mem_size, es_mem_sign_ext, es_excp, es_sideband, data_data_ok, data_rdata,
           flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_excp,
           ms_sideband, ms_flush, ms_fwd_en, ms_fwd_stall, ms_fwd_data
  );

  modport master (
    output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op, es_store_op,
           es_mem_size, es_mem_sign_ext, es_excp, es_sideband, data_data_ok, data_rdata,
           flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_excp,
           ms_sideband, ms_flush, ms_fwd_en, ms_fwd_stall, ms_fwd_data
  );
endinterface

// File: rtl/mem_stage.sv
// LoongArch memory stage: waits for data_ok, aligns/extends load data, buffers one response,
// drops responses of flushed ops. Define MS_FWD_LOAD_EN to forward load data in its data_ok cycle.
module mem_stage #(
  parameter int SB_WD  = 64,
  parameter int DISC_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);
  localparam logic [DISC_W-1:0] DISC_MAX = '1;

  logic              ms_valid_reg;
  logic              wait_resp_reg;
  logic              buf_valid_reg;
  logic [31:0]       buf_data_reg;
  logic [DISC_W-1:0] disc_cnt_reg;
  logic [DISC_W-1:0] disc_cnt_next;
  logic [31:0]       pc_reg;
  logic [31:0]       result_reg;
  logic [4:0]        dest_reg;
  logic              gr_we_reg;
  logic              load_op_reg;
  logic              excp_reg;
  logic [1:0]        mem_size_reg;
  logic              sign_ext_reg;
  logic [SB_WD-1:0]  sideband_reg;

  logic        delivered;
  logic        orphan;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        accept;
  logic        handoff;
  logic [31:0] load_data;
  logic [31:0] shifted;
  logic [31:0] load_result;
  logic [31:0] final_result;

  // A response belongs to the live op only once all responses of flushed ops have drained.
  assign delivered      = bus.data_data_ok & (disc_cnt_reg == '0);
  assign orphan         = bus.data_data_ok & (disc_cnt_reg != '0);
  assign ms_ready_go    = !wait_resp_reg | delivered | buf_valid_reg;
  assign ms_allowin     = !ms_valid_reg | (ms_ready_go & bus.ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg & ms_ready_go;
  assign accept         = bus.es_to_ms_valid & ms_allowin;
  assign handoff        = ms_to_ws_valid & bus.ws_allowin;

  always_comb begin
    load_data = buf_valid_reg ? buf_data_reg : bus.data_rdata;
    shifted   = load_data;
    if (mem_size_reg[0]) begin
      shifted = load_data >> {result_reg[1:0], 3'b000};
    end else if (mem_size_reg[1]) begin
      shifted = load_data >> {result_reg[1], 4'b0000};
    end
  end

  // Per-bit extension: byte ops fill from bit 7, half ops from bit 15 above their width.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ext
      if (gi < 8) begin : g_lo
        assign load_result[gi] = shifted[gi];
      end else if (gi < 16) begin : g_mid
        assign load_result[gi] = mem_size_reg[0] ? (sign_ext_reg & shifted[7]) : shifted[gi];
      end else begin : g_hi
        assign load_result[gi] = mem_size_reg[0] ? (sign_ext_reg & shifted[7]) :
                                 mem_size_reg[1] ? (sign_ext_reg & shifted[15]) : shifted[gi];
      end
    end
  endgenerate

  assign final_result = (load_op_reg & !excp_reg) ? load_result : result_reg;

  always_comb begin
    disc_cnt_next = disc_cnt_reg;
    if (bus.flush & wait_resp_reg & !delivered) begin
      // an orphan draining in the same cycle cancels the new one
      if (!orphan && (disc_cnt_reg != DISC_MAX)) begin
        disc_cnt_next = disc_cnt_reg + 1'b1;
      end
    end else if (orphan) begin
      disc_cnt_next = disc_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg  <= 1'b0;
      wait_resp_reg <= 1'b0;
      buf_valid_reg <= 1'b0;
      buf_data_reg  <= '0;
      disc_cnt_reg  <= '0;
      pc_reg        <= '0;
      result_reg    <= '0;
      dest_reg      <= '0;
      gr_we_reg     <= 1'b0;
      load_op_reg   <= 1'b0;
      excp_reg      <= 1'b0;
      mem_size_reg  <= '0;
      sign_ext_reg  <= 1'b0;
      sideband_reg  <= '0;
    end else begin
      disc_cnt_reg <= disc_cnt_next;
      if (bus.flush) begin
        ms_valid_reg  <= 1'b0;
        wait_resp_reg <= 1'b0;
        buf_valid_reg <= 1'b0;
      end else begin
        if (ms_allowin) begin
          ms_valid_reg <= bus.es_to_ms_valid;
        end
        if (accept) begin
          wait_resp_reg <= (bus.es_load_op | bus.es_store_op) & !bus.es_excp;
          pc_reg        <= bus.es_pc;
          result_reg    <= bus.es_result;
          dest_reg      <= bus.es_dest;
          gr_we_reg     <= bus.es_gr_we;
          load_op_reg   <= bus.es_load_op;
          excp_reg      <= bus.es_excp;
          mem_size_reg  <= bus.es_mem_size;
          sign_ext_reg  <= bus.es_mem_sign_ext;
          sideband_reg  <= bus.es_sideband;
        end else if (delivered) begin
          wait_resp_reg <= 1'b0;
        end
        if (handoff) begin
          buf_valid_reg <= 1'b0;
        end else if (delivered & wait_resp_reg & !bus.ws_allowin) begin
          buf_valid_reg <= 1'b1;
          buf_data_reg  <= bus.data_rdata;
        end
      end
    end
  end

  assign bus.ms_allowin      = ms_allowin;
  assign bus.ms_to_ws_valid  = ms_to_ws_valid;
  assign bus.ms_pc           = pc_reg;
  assign bus.ms_final_result = final_result;
  assign bus.ms_dest         = dest_reg;
  assign bus.ms_gr_we        = gr_we_reg;
  assign bus.ms_excp         = excp_reg;
  assign bus.ms_sideband     = sideband_reg;
  assign bus.ms_flush        = ms_valid_reg & excp_reg;
  assign bus.ms_fwd_en       = ms_valid_reg & gr_we_reg & (dest_reg != 5'd0);
  assign bus.ms_fwd_data     = final_result;
`ifdef MS_FWD_LOAD_EN
  assign bus.ms_fwd_stall    = ms_valid_reg & load_op_reg & !ms_ready_go;
`else
  assign bus.ms_fwd_stall    = ms_valid_reg & load_op_reg;
`endif
endmodule
